// File: rtl/mixer_pipelined_if.sv
// mixer_pipelined_if: sample-stream bundle between the voice generators, the
// mixer and the codec serialiser.
//
// Handshake: valid-only, no ready. A sample set is transferred on every rising
// clk edge where in_valid (resp. out_valid) is 1; the receiver must accept it
// in that cycle, there is no backpressure.
interface mixer_pipelined_if #(
    parameter int NUM_CH = 4,
    parameter int IN_W   = 8,
    parameter int GAIN_W = 4,
    parameter int OUT_W  = 16
);
    logic                     in_valid;
    logic [NUM_CH*IN_W-1:0]   audio_in;
    logic [NUM_CH*GAIN_W-1:0] gain;
    logic [NUM_CH-1:0]        ch_mute;
    logic                     out_valid;
    logic [OUT_W-1:0]         mix_out;
    logic                     clip;

    // Producer side: drives samples, observes the mixed result.
    modport master (
        output in_valid, audio_in, gain, ch_mute,
        input  out_valid, mix_out, clip
    );

    // Mixer side.
    modport slave (
        input  in_valid, audio_in, gain, ch_mute,
        output out_valid, mix_out, clip
    );
endinterface

// File: rtl/mixer_pipelined.sv
// mixer_pipelined: N-channel audio mixer. Per-channel gain (2 fractional bits)
// and mute, registered binary adder tree, saturation to OUT_W. A valid bit
// travels alongside the data; latency is log2(NUM_CH)+2 cycles, one sample set
// per cycle throughput.
//
// Optional macro MIXER_PEAK_HOLD_EN adds the peak/peak_clr ports and a
// peak-hold register on the output.
module mixer_pipelined #(
    parameter int NUM_CH = 4,
    parameter int IN_W   = 8,
    parameter int GAIN_W = 4,
    parameter int OUT_W  = 16
) (
    input  logic             clk,
    input  logic             resetn,
    mixer_pipelined_if.slave bus
`ifdef MIXER_PEAK_HOLD_EN
    ,
    input  logic             peak_clr,
    output logic [OUT_W-1:0] peak
`endif
);

    localparam int L   = $clog2(NUM_CH);     // adder tree depth
    localparam int PRW = IN_W + GAIN_W;      // raw product width
    localparam int PW  = IN_W + GAIN_W - 2;  // product width after >>2
    localparam int S   = PW + L;             // full sum width

    // Reject configurations the tree or the output stage cannot handle.
    if ((NUM_CH < 2) || (NUM_CH > 16) || ((NUM_CH & (NUM_CH - 1)) != 0)) begin : g_bad_num_ch
        $error("mixer_pipelined: NUM_CH must be a power of two in 2..16");
    end
    if (OUT_W < IN_W) begin : g_bad_out_w
        $error("mixer_pipelined: OUT_W must be >= IN_W");
    end

    // Level 0 is the gain stage, levels 1..L are the adder tree. Level lv holds
    // NUM_CH>>lv partial sums of width PW+lv, so no level can overflow.
    for (genvar lv = 0; lv <= L; lv++) begin : lvl
        localparam int W = PW + lv;
        localparam int N = NUM_CH >> lv;
        logic [W-1:0] s_q [N];

        if (lv == 0) begin : g_gain
            logic [PRW-1:0] prod [NUM_CH];

            // Full-width sample*gain product per channel.
            always_comb begin
                for (int k = 0; k < NUM_CH; k++) begin
                    prod[k] = PRW'(bus.audio_in[k*IN_W +: IN_W]) *
                              PRW'(bus.gain[k*GAIN_W +: GAIN_W]);
                end
            end

            // Drop the two fractional bits (truncate) and apply mute.
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    for (int k = 0; k < NUM_CH; k++) s_q[k] <= '0;
                end else begin
                    for (int k = 0; k < NUM_CH; k++) begin
                        s_q[k] <= bus.ch_mute[k] ? '0 : W'(prod[k] >> 2);
                    end
                end
            end
        end else begin : g_add
            // Sum adjacent pairs of the previous level, one bit wider.
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    for (int j = 0; j < N; j++) s_q[j] <= '0;
                end else begin
                    for (int j = 0; j < N; j++) begin
                        s_q[j] <= W'(lvl[lv-1].s_q[2*j]) + W'(lvl[lv-1].s_q[2*j+1]);
                    end
                end
            end
        end
    end

    logic [S-1:0]     sum;
    logic [OUT_W-1:0] mix_d;
    logic             clip_d;

    assign sum = lvl[L].s_q[0];

    // Saturate only when the sum can actually exceed the output range.
    if (S > OUT_W) begin : g_sat
        logic over;
        assign over   = |sum[S-1:OUT_W];
        assign mix_d  = over ? '1 : sum[OUT_W-1:0];
        assign clip_d = over;
    end else begin : g_nosat
        assign mix_d  = OUT_W'(sum);
        assign clip_d = 1'b0;
    end

    // vld_q[i] marks the data held in level i; vld_q[L+1] is out_valid.
    logic [L+1:0]     vld_q;
    logic [OUT_W-1:0] mix_q;
    logic             clip_q;

    // Valid chain shifts every cycle; the output register only captures a
    // result when the tree's last level holds a valid sample.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_q  <= '0;
            mix_q  <= '0;
            clip_q <= 1'b0;
        end else begin
            vld_q <= {vld_q[L:0], bus.in_valid};
            if (vld_q[L]) begin
                mix_q  <= mix_d;
                clip_q <= clip_d;
            end
        end
    end

    assign bus.out_valid = vld_q[L+1];
    assign bus.mix_out   = mix_q;
    assign bus.clip      = clip_q;

`ifdef MIXER_PEAK_HOLD_EN
    logic [OUT_W-1:0] peak_q;

    // Track the largest emitted sample; a clear wins over a same-cycle capture.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            peak_q <= '0;
        end else if (peak_clr) begin
            peak_q <= '0;
        end else if (vld_q[L+1] && (mix_q > peak_q)) begin
            peak_q <= mix_q;
        end
    end

    assign peak = peak_q;
`endif

endmodule

// File: doc/mixer_pipelined.md
Name: mixer_pipelined

Overview:
Parametrised N-channel audio mixer for the project's sound path.
- Applies per-channel gain and mute, sums all channels through a registered binary adder tree, and saturates the result to the output width.
- A valid bit travels with each sample through the pipeline.
- Sits between the per-voice sample generators and the audio codec serialiser. Replaces the fixed 4-input, 8-bit two-stage mixer.

Parameters:
NUM_CH, 4, channel count; power of two, 2..16
IN_W, 8, unsigned sample width per channel
GAIN_W, 4, unsigned gain width per channel; fixed point with 2 fractional bits (gain 4 = unity)
OUT_W, 16, unsigned mixed output width

Ports:
clk  input  1  system clock, rising edge
resetn  input  1  asynchronous active-low reset
in_valid  input  1  audio_in holds a new sample set this cycle
audio_in  input  NUM_CH*IN_W  channel samples, channel k at bits [k*IN_W +: IN_W]
gain  input  NUM_CH*GAIN_W  per-channel gain, channel k at bits [k*GAIN_W +: GAIN_W]
ch_mute  input  NUM_CH  1 = channel k contributes 0
out_valid  output  1  mix_out/clip hold a new result this cycle
mix_out  output  OUT_W  mixed, saturated sample
clip  output  1  the mix_out currently presented was saturated
peak  output  OUT_W  peak-hold value (only with MIXER_PEAK_HOLD_EN)
peak_clr  input  1  clears peak (only with MIXER_PEAK_HOLD_EN)

Behaviour:
- Reset (resetn low, asynchronous): all pipeline data and valid registers cleared. out_valid=0, mix_out=0, clip=0, peak=0. Deassertion is synchronous to clk by the system reset bridge.
- Reset mid-operation: in-flight samples are discarded, never emitted.
- Stage G (cycle 1): per channel, p_k = ch_mute[k] ? 0 : (audio_in_k * gain_k) >> 2, truncating.
  - Product width IN_W+GAIN_W; registered width IN_W+GAIN_W-2.
  - gain=0 gives 0; gain=15 gives 3.75x.
- Tree stages T1..TL, with L = log2(NUM_CH): each level adds adjacent pairs and registers the sums.
  - Width grows by 1 bit per level, so there is no intermediate overflow.
  - Full sum width S = IN_W+GAIN_W-2+L.
- Stage O: if sum > 2^OUT_W-1, mix_out = all ones and clip=1; else mix_out = sum zero-extended and clip=0.
  - If S <= OUT_W, clip is constant 0.
- Latency: out_valid asserts exactly L+2 cycles after the in_valid cycle (4 cycles at defaults). Throughput is one sample set per cycle.
- Valid handling:
  - The valid bit shifts through a (L+2)-deep register chain.
  - Data registers load every cycle.
  - mix_out and clip update only when the final-stage valid is 1, and otherwise hold their last value.
  - out_valid is a single-cycle pulse per input sample.
- Back-to-back and gapped in_valid: each sample emerges in order with the identical gap pattern. There is no backpressure; the consumer must accept every out_valid.
- Gain and mute are sampled in the same cycle as audio_in. Changes apply to that sample only, with no smoothing.
- Elaboration error if NUM_CH is not a power of two in 2..16, or OUT_W < IN_W.

Optional Feature:
MIXER_PEAK_HOLD_EN
- Defined:
  - peak updates to mix_out whenever out_valid=1 and mix_out > peak.
  - peak_clr=1 sets peak to 0 on the next edge. peak_clr has priority over a simultaneous update, so that sample is not captured.
- Undefined: peak and peak_clr ports are absent and no peak logic is generated.

Test Plan:
- Reset, then defaults: in_valid pulse with all channels 100, gain 4, no mute -> out_valid exactly 4 cycles later, mix_out=400, clip=0.
- Gain/mute: ch0=200 gain 8, ch1=50 gain 2, ch2=255 muted, ch3=10 gain 0 -> mix_out=425.
- Saturation with OUT_W=10: all channels 255, gain 15 (956 each, sum 3824) -> mix_out=1023, clip=1. Next sample all 1, gain 4 -> mix_out=4, clip=0.
- Streaming: in_valid high 8 cycles with ramp 1..8 on all channels at unity, then 2-cycle gap and one more (9) -> outputs 4,8,...,32 on consecutive cycles, a 2-cycle gap, then 36. mix_out holds 32 during the gap.
- Reset mid-stream: assert resetn low while 3 samples are in flight -> out_valid never pulses for them, and all outputs read 0 immediately (asynchronous).
- MIXER_PEAK_HOLD_EN: outputs 300, 900, 500 -> peak=900. peak_clr pulsed together with a 700 output -> peak=0; next output 200 -> peak=200.
